// File: rtl/torrence_params.sv
// Shared types and width helpers for the torrence memory subsystem.
//   memory_operation_size_e : access size seen by the data array and the CPU port
//   cache_state_e           : cache controller FSM states
//   idx_w / tag_w           : address-field widths derived from cache geometry
package torrence_params;

    typedef enum logic [1:0] {
        BYTE = 2'd0,
        HALF = 2'd1,
        WORD = 2'd2
    } memory_operation_size_e;

    typedef enum logic [1:0] {
        CACHE_IDLE      = 2'd0,
        CACHE_LOOKUP    = 2'd1,
        CACHE_WRITEBACK = 2'd2,
        CACHE_FILL      = 2'd3
    } cache_state_e;

    // Index width for n entries; never zero so a one-entry dimension stays addressable.
    function automatic int idx_w(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

    // Tag width once byte offset, word offset and set index are removed.
    function automatic int tag_w(input int xlen, input int sets, input int words);
        return xlen - 2 - idx_w(words) - idx_w(sets);
    endfunction

endpackage

// File: rtl/cache_tag_store.sv
// Tag/valid/dirty array with hit compare, victim choice and per-set round-robin.
//   lookup_set/lookup_tag : set being serviced and tag being searched
//   hit/hit_way           : tag match among valid ways
//   victim_*              : way to replace (lowest invalid, else round-robin) and its state
//   set_dirty             : mark the hit way dirty
//   clr_dirty             : clear dirty on upd_way after writeback
//   fill_done             : install lookup_tag in upd_way, valid=1, dirty=0, bump pointer
module cache_tag_store
    import torrence_params::*;
#(
    parameter int NUM_SETS = 4,
    parameter int ASSOC    = 2,
    parameter int TAG_W    = 25,
    parameter int SET_W    = idx_w(NUM_SETS),
    parameter int WAY_W    = idx_w(ASSOC)
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [SET_W-1:0] lookup_set,
    input  logic [TAG_W-1:0] lookup_tag,
    output logic             hit,
    output logic [WAY_W-1:0] hit_way,
    output logic [WAY_W-1:0] victim_way,
    output logic             victim_valid,
    output logic             victim_dirty,
    output logic [TAG_W-1:0] victim_tag,
    input  logic             set_dirty,
    input  logic             clr_dirty,
    input  logic             fill_done,
    input  logic [WAY_W-1:0] upd_way
);

    logic [TAG_W-1:0]                tags [NUM_SETS][ASSOC];
    logic [NUM_SETS-1:0][ASSOC-1:0]  valid;
    logic [NUM_SETS-1:0][ASSOC-1:0]  dirty;
    logic [NUM_SETS-1:0][WAY_W-1:0]  rr;

    always_comb begin
        hit     = 1'b0;
        hit_way = '0;
        for (int w = 0; w < ASSOC; w++) begin
            if (valid[lookup_set][w] && tags[lookup_set][w] == lookup_tag) begin
                hit     = 1'b1;
                hit_way = WAY_W'(w);
            end
        end
    end

    // Walk downwards so the lowest-index invalid way is the one that sticks.
    always_comb begin
        victim_way = rr[lookup_set];
        for (int w = ASSOC - 1; w >= 0; w--) begin
            if (!valid[lookup_set][w]) victim_way = WAY_W'(w);
        end
    end

    assign victim_valid = valid[lookup_set][victim_way];
    assign victim_dirty = dirty[lookup_set][victim_way];
    assign victim_tag   = tags[lookup_set][victim_way];

    // Tags need no reset: a line is only trusted once its valid bit is set.
    always_ff @(posedge clk) begin
        if (fill_done) tags[lookup_set][upd_way] <= lookup_tag;
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            valid <= '0;
            dirty <= '0;
            rr    <= '0;
        end else if (fill_done) begin
            valid[lookup_set][upd_way] <= 1'b1;
            dirty[lookup_set][upd_way] <= 1'b0;
            rr[lookup_set] <= (rr[lookup_set] == WAY_W'(ASSOC - 1)) ? '0 : rr[lookup_set] + 1'b1;
        end else if (set_dirty) begin
            dirty[lookup_set][hit_way] <= 1'b1;
        end else if (clr_dirty) begin
            dirty[lookup_set][upd_way] <= 1'b0;
        end
    end

endmodule

// File: rtl/cache_controller.sv
// Write-back, write-allocate set-associative cache controller.
//   req_* / resp_*  : CPU side, one request in flight, response pulse per request
//   mem_*           : word-wide backing memory, one transaction outstanding at a time
//   dl_*            : drives the parent's datalines (data-only) array; dl_fetched_word
//                     is its combinational read of the selected set/way/word
module cache_controller
    import torrence_params::*;
#(
    parameter int XLEN           = 32,
    parameter int NUM_SETS       = 4,
    parameter int WORDS_PER_LINE = 8,
    parameter int ASSOC          = 2
) (
    input  logic                              clk,
    input  logic                              reset,
    input  logic                              req_valid,
    output logic                              req_ready,
    input  logic [XLEN-1:0]                   req_addr,
    input  logic                              req_rw,
    input  memory_operation_size_e            req_size,
    input  logic [XLEN-1:0]                   req_wdata,
    output logic                              resp_valid,
    output logic [XLEN-1:0]                   resp_rdata,
    output logic                              mem_req_valid,
    input  logic                              mem_req_ready,
    output logic                              mem_req_rw,
    output logic [XLEN-1:0]                   mem_req_addr,
    output logic [XLEN-1:0]                   mem_wdata,
    input  logic                              mem_resp_valid,
    input  logic [XLEN-1:0]                   mem_rdata,
    output logic                              dl_perform_write,
    output logic [idx_w(NUM_SETS)-1:0]        dl_set,
    output logic [idx_w(ASSOC)-1:0]           dl_way,
    output logic [idx_w(WORDS_PER_LINE)-1:0]  dl_word_select,
    output logic [1:0]                        dl_byte_select,
    output memory_operation_size_e            dl_op_size,
    output logic [XLEN-1:0]                   dl_word_to_store,
    input  logic [XLEN-1:0]                   dl_fetched_word
);

    localparam int WORD_W = idx_w(WORDS_PER_LINE);
    localparam int SET_W  = idx_w(NUM_SETS);
    localparam int WAY_W  = idx_w(ASSOC);
    localparam int TAG_W  = tag_w(XLEN, NUM_SETS, WORDS_PER_LINE);
    localparam logic [WORD_W-1:0] LAST_BEAT = WORD_W'(WORDS_PER_LINE - 1);

    cache_state_e            state;
    logic [XLEN-1:0]         addr_q;
    logic [XLEN-1:0]         wdata_q;
    logic                    rw_q;
    memory_operation_size_e  size_q;
    logic [WORD_W-1:0]       beat;
    logic                    wait_resp;   // fill read accepted, data not yet returned
    logic [WAY_W-1:0]        vic_way_q;
    logic [TAG_W-1:0]        vic_tag_q;

    logic [1:0]              a_byte;
    logic [WORD_W-1:0]       a_word;
    logic [SET_W-1:0]        a_set;
    logic [TAG_W-1:0]        a_tag;

    assign {a_tag, a_set, a_word, a_byte} = addr_q;

    logic             hit, victim_valid, victim_dirty;
    logic [WAY_W-1:0] hit_way, victim_way;
    logic [TAG_W-1:0] victim_tag;
    logic             set_dirty, clr_dirty, fill_done;

    cache_tag_store #(
        .NUM_SETS (NUM_SETS),
        .ASSOC    (ASSOC),
        .TAG_W    (TAG_W)
    ) u_tags (
        .clk          (clk),
        .reset        (reset),
        .lookup_set   (a_set),
        .lookup_tag   (a_tag),
        .hit          (hit),
        .hit_way      (hit_way),
        .victim_way   (victim_way),
        .victim_valid (victim_valid),
        .victim_dirty (victim_dirty),
        .victim_tag   (victim_tag),
        .set_dirty    (set_dirty),
        .clr_dirty    (clr_dirty),
        .fill_done    (fill_done),
        .upd_way      (vic_way_q)
    );

    logic mem_fire, beat_last, fill_beat;

    assign mem_fire  = mem_req_valid && mem_req_ready;
    assign beat_last = (beat == LAST_BEAT);
    assign fill_beat = (state == CACHE_FILL) && wait_resp && mem_resp_valid;

    always_comb begin
        req_ready        = (state == CACHE_IDLE);
        resp_valid       = 1'b0;
        resp_rdata       = '0;
        mem_req_valid    = 1'b0;
        mem_req_rw       = 1'b0;
        mem_req_addr     = '0;
        mem_wdata        = '0;
        dl_perform_write = 1'b0;
        dl_set           = a_set;
        dl_way           = vic_way_q;
        dl_word_select   = a_word;
        dl_byte_select   = a_byte;
        dl_op_size       = size_q;
        dl_word_to_store = wdata_q;
        set_dirty        = 1'b0;
        clr_dirty        = 1'b0;
        fill_done        = 1'b0;
        case (state)
            CACHE_LOOKUP: begin
                dl_way = hit_way;
                if (hit) begin
                    resp_valid = 1'b1;
                    if (rw_q) begin
                        dl_perform_write = 1'b1;
                        set_dirty        = 1'b1;
                    end else begin
                        resp_rdata = dl_fetched_word;
                    end
                end
            end
            CACHE_WRITEBACK: begin
                dl_word_select = beat;
                dl_op_size     = WORD;
                mem_req_valid  = 1'b1;
                mem_req_rw     = 1'b1;
                mem_req_addr   = {vic_tag_q, a_set, beat, 2'b00};
                mem_wdata      = dl_fetched_word;
                clr_dirty      = mem_fire && beat_last;
            end
            CACHE_FILL: begin
                dl_word_select   = beat;
                dl_op_size       = WORD;
                dl_word_to_store = mem_rdata;
                mem_req_valid    = !wait_resp;
                mem_req_addr     = {a_tag, a_set, beat, 2'b00};
                dl_perform_write = fill_beat;
                fill_done        = fill_beat && beat_last;
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state     <= CACHE_IDLE;
            addr_q    <= '0;
            wdata_q   <= '0;
            rw_q      <= 1'b0;
            size_q    <= WORD;
            beat      <= '0;
            wait_resp <= 1'b0;
            vic_way_q <= '0;
            vic_tag_q <= '0;
        end else begin
            case (state)
                CACHE_IDLE: begin
                    if (req_valid) begin
                        addr_q  <= req_addr;
                        wdata_q <= req_wdata;
                        rw_q    <= req_rw;
                        size_q  <= req_size;
                        state   <= CACHE_LOOKUP;
                    end
                end
                CACHE_LOOKUP: begin
                    if (hit) begin
                        state <= CACHE_IDLE;
                    end else begin
                        // Victim is captured here so later tag-store updates cannot move it.
                        vic_way_q <= victim_way;
                        vic_tag_q <= victim_tag;
                        beat      <= '0;
                        wait_resp <= 1'b0;
                        state     <= (victim_valid && victim_dirty) ? CACHE_WRITEBACK : CACHE_FILL;
                    end
                end
                CACHE_WRITEBACK: begin
                    if (mem_fire) begin
                        beat <= beat_last ? '0 : beat + 1'b1;
                        if (beat_last) state <= CACHE_FILL;
                    end
                end
                CACHE_FILL: begin
                    if (!wait_resp) begin
                        if (mem_req_ready) wait_resp <= 1'b1;
                    end else if (mem_resp_valid) begin
                        wait_resp <= 1'b0;
                        beat      <= beat_last ? '0 : beat + 1'b1;
                        if (beat_last) state <= CACHE_LOOKUP;
                    end
                end
                default: state <= CACHE_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_cache_controller.sv
// Scoreboarded bench for cache_controller with a behavioural data array and memory.
module tb_cache_controller;
    import torrence_params::*;

    logic                   clk = 1'b0;
    logic                   reset;
    logic                   req_valid, req_ready, req_rw;
    logic [31:0]            req_addr, req_wdata;
    memory_operation_size_e req_size;
    logic                   resp_valid;
    logic [31:0]            resp_rdata;
    logic                   mem_req_valid, mem_req_ready, mem_req_rw;
    logic [31:0]            mem_req_addr, mem_wdata;
    logic                   mem_resp_valid;
    logic [31:0]            mem_rdata;
    logic                   dl_perform_write;
    logic [1:0]             dl_set;
    logic [0:0]             dl_way;
    logic [2:0]             dl_word_select;
    logic [1:0]             dl_byte_select;
    memory_operation_size_e dl_op_size;
    logic [31:0]            dl_word_to_store, dl_fetched_word;

    always #5 clk = ~clk;

    cache_controller dut (
        .clk(clk), .reset(reset),
        .req_valid(req_valid), .req_ready(req_ready), .req_addr(req_addr),
        .req_rw(req_rw), .req_size(req_size), .req_wdata(req_wdata),
        .resp_valid(resp_valid), .resp_rdata(resp_rdata),
        .mem_req_valid(mem_req_valid), .mem_req_ready(mem_req_ready),
        .mem_req_rw(mem_req_rw), .mem_req_addr(mem_req_addr), .mem_wdata(mem_wdata),
        .mem_resp_valid(mem_resp_valid), .mem_rdata(mem_rdata),
        .dl_perform_write(dl_perform_write), .dl_set(dl_set), .dl_way(dl_way),
        .dl_word_select(dl_word_select), .dl_byte_select(dl_byte_select),
        .dl_op_size(dl_op_size), .dl_word_to_store(dl_word_to_store),
        .dl_fetched_word(dl_fetched_word)
    );

    // Datalines stand-in: async read, sized write with data in the low lanes.
    logic [31:0] dl_arr [4][2][8];
    assign dl_fetched_word = dl_arr[dl_set][dl_way][dl_word_select];
    always @(posedge clk) begin
        if (dl_perform_write) begin
            case (dl_op_size)
                BYTE:    dl_arr[dl_set][dl_way][dl_word_select][8*dl_byte_select +: 8] <= dl_word_to_store[7:0];
                HALF:    dl_arr[dl_set][dl_way][dl_word_select][16*dl_byte_select[1] +: 16] <= dl_word_to_store[15:0];
                default: dl_arr[dl_set][dl_way][dl_word_select] <= dl_word_to_store;
            endcase
        end
    end

    // Backing memory and an independent CPU-view reference.
    logic [31:0] mem_q   [logic [31:0]];
    logic [31:0] ref_mem [logic [31:0]];
    logic [32:0] mlog [$];           // {rw, addr} per accepted memory request
    logic [31:0] exp_q [$];
    int          mem_req_cycles;
    int          n_chk = 0, n_pass = 0;
    logic [31:0] last_rdata;

    function automatic logic [31:0] init_word(input logic [31:0] a);
        return 32'hA500_0000 | a;
    endfunction
    function automatic logic [31:0] mem_rd(input logic [31:0] a);
        return mem_q.exists(a) ? mem_q[a] : init_word(a);
    endfunction
    function automatic logic [31:0] ref_rd(input logic [31:0] a);
        return ref_mem.exists(a) ? ref_mem[a] : init_word(a);
    endfunction

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %h expected %h", tag, got, exp);
    endtask

    // Memory responder: handshakes seen at negedge complete on the next posedge;
    // read data is returned one cycle later.
    initial begin
        logic        pend;
        logic [31:0] pend_addr;
        pend = 1'b0; pend_addr = '0;
        mem_resp_valid = 1'b0; mem_rdata = '0; mem_req_cycles = 0;
        forever begin
            @(negedge clk);
            mem_resp_valid = 1'b0;
            if (reset) begin
                pend = 1'b0;
            end else begin
                if (pend) begin
                    mem_resp_valid = 1'b1;
                    mem_rdata = mem_rd(pend_addr);
                    pend = 1'b0;
                end
                if (mem_req_valid) mem_req_cycles++;
                if (mem_req_valid && mem_req_ready) begin
                    mlog.push_back({mem_req_rw, mem_req_addr});
                    if (mem_req_rw) mem_q[mem_req_addr] = mem_wdata;
                    else begin pend = 1'b1; pend_addr = mem_req_addr; end
                end
            end
        end
    end

    // Response monitor: every response pops the scoreboard.
    initial forever begin
        @(negedge clk);
        if (!reset && resp_valid) begin
            last_rdata = resp_rdata;
            if (exp_q.size() == 0) chk("resp_unexpected", exp_q.size(), 1);
            else chk("resp_data", resp_rdata, exp_q.pop_front());
        end
    end

    task automatic clear_logs();
        mlog.delete();
        mem_req_cycles = 0;
    endtask

    task automatic send(input logic [31:0] a, input logic rw, input memory_operation_size_e sz,
                        input logic [31:0] wd);
        bit done = 0;
        if (rw) begin
            logic [31:0] w;
            w = ref_rd({a[31:2], 2'b00});
            case (sz)
                BYTE:    w[8*a[1:0] +: 8] = wd[7:0];
                HALF:    w[16*a[1] +: 16] = wd[15:0];
                default: w = wd;
            endcase
            ref_mem[{a[31:2], 2'b00}] = w;
            exp_q.push_back(32'h0);
        end else begin
            exp_q.push_back(ref_rd({a[31:2], 2'b00}));
        end
        req_valid = 1'b1; req_addr = a; req_rw = rw; req_size = sz; req_wdata = wd;
        for (int i = 0; i < 50 && !done; i++) begin
            done = req_ready;
            @(posedge clk); #1;
        end
        req_valid = 1'b0;
        if (!done) chk("accept_timeout", {31'b0, req_ready}, 1);
    endtask

    // Called one time unit after the accepting edge; lat counts cycles to resp_valid.
    task automatic wait_resp(output int lat);
        lat = 0;
        for (int i = 0; i < 500; i++) begin
            @(negedge clk);
            lat++;
            if (resp_valid) break;
        end
        if (!resp_valid) chk("resp_timeout", {31'b0, resp_valid}, 1);
        @(posedge clk); #1;
    endtask

    task automatic xact(input logic [31:0] a, input logic rw, input memory_operation_size_e sz,
                        input logic [31:0] wd, output int lat);
        clear_logs();
        send(a, rw, sz, wd);
        wait_resp(lat);
    endtask

    task automatic chk_beats(input string tag, input int start, input logic rw, input logic [31:0] base);
        for (int i = 0; i < 8; i++)
            chk(tag, (start + i < mlog.size()) ? mlog[start + i][31:0] : 32'hDEAD_DEAD,
                base + 32'(4 * i));
        for (int i = 0; i < 8; i++)
            if (start + i < mlog.size()) chk({tag, "_rw"}, {31'b0, mlog[start + i][32]}, {31'b0, rw});
    endtask

    initial begin
        int lat;
        logic [31:0] a0, w40;
        reset = 1'b1; req_valid = 1'b0; req_addr = '0; req_rw = 1'b0;
        req_size = WORD; req_wdata = '0; mem_req_ready = 1'b1;
        repeat (3) @(posedge clk);
        #1 reset = 1'b0;
        #1;
        chk("rst_req_ready", {31'b0, req_ready}, 1);
        chk("rst_resp_valid", {31'b0, resp_valid}, 0);
        chk("rst_mem_req_valid", {31'b0, mem_req_valid}, 0);
        chk("rst_dl_write", {31'b0, dl_perform_write}, 0);
        @(posedge clk); #1;

        // Cold miss: 8-beat fill, no writeback.
        xact(32'h40, 1'b0, WORD, '0, lat);
        chk("cold_nbeats", mlog.size(), 8);
        chk_beats("cold_fill", 0, 1'b0, 32'h40);

        // Hit on same line: 1-cycle latency, no memory traffic.
        xact(32'h44, 1'b0, WORD, '0, lat);
        chk("hit_latency", lat, 1);
        chk("hit_no_mem", mem_req_cycles, 0);

        // Byte store then word load.
        xact(32'h41, 1'b1, BYTE, 32'h0000_00AB, lat);
        chk("store_latency", lat, 1);
        xact(32'h40, 1'b0, WORD, '0, lat);
        w40 = init_word(32'h40);
        chk("store_byte1", {24'b0, last_rdata[15:8]}, 32'hAB);
        chk("store_others", {last_rdata[31:16], 8'h00, last_rdata[7:0]}, {w40[31:16], 8'h00, w40[7:0]});

        // Second way of set 2, then the conflicting third line evicts dirty way 0.
        xact(32'h140, 1'b0, WORD, '0, lat);
        chk("way1_nbeats", mlog.size(), 8);
        chk_beats("way1_fill", 0, 1'b0, 32'h140);
        xact(32'h240, 1'b0, WORD, '0, lat);
        chk("evict_nbeats", mlog.size(), 16);
        chk_beats("evict_wb", 0, 1'b1, 32'h40);
        chk_beats("evict_fill", 8, 1'b0, 32'h240);
        chk("wb_data", mem_rd(32'h40), ref_rd(32'h40));
        xact(32'h144, 1'b0, WORD, '0, lat);
        chk("way1_kept", lat, 1);
        xact(32'h40, 1'b0, WORD, '0, lat);
        chk("way0_replaced", mlog.size(), 8);

        // Memory back-pressure during fill.
        clear_logs();
        mem_req_ready = 1'b0;
        send(32'h340, 1'b0, WORD, '0);
        for (int i = 0; i < 20 && !mem_req_valid; i++) begin @(posedge clk); #1; end
        a0 = mem_req_addr;
        chk("stall_addr0", a0, 32'h340);
        for (int i = 0; i < 5; i++) begin
            @(posedge clk); #1;
            chk("stall_valid", {31'b0, mem_req_valid}, 1);
            chk("stall_addr", mem_req_addr, a0);
            chk("stall_req_ready", {31'b0, req_ready}, 0);
        end
        mem_req_ready = 1'b1;
        wait_resp(lat);
        chk_beats("stall_fill", 0, 1'b0, 32'h340);

        // Reset during fill beat 3 abandons the line.
        clear_logs();
        send(32'hC0, 1'b0, WORD, '0);
        for (int i = 0; i < 100 && mlog.size() < 4; i++) begin @(posedge clk); #2; end
        reset = 1'b1;
        exp_q.delete();
        #1;
        chk("midrst_resp_valid", {31'b0, resp_valid}, 0);
        chk("midrst_mem_req_valid", {31'b0, mem_req_valid}, 0);
        chk("midrst_dl_write", {31'b0, dl_perform_write}, 0);
        chk("midrst_req_ready", {31'b0, req_ready}, 1);
        repeat (2) @(posedge clk);
        #1 reset = 1'b0;
        @(posedge clk); #1;
        xact(32'hC0, 1'b0, WORD, '0, lat);
        chk("refill_nbeats", mlog.size(), 8);
        chk_beats("refill", 0, 1'b0, 32'hC0);
        chk("scoreboard_empty", exp_q.size(), 0);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL global_timeout: got running expected finished");
        $fatal(1);
    end

endmodule
